// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, default multiplier latency and result entry type
package mul_pkg;
  localparam int OP_W            = 32;
  localparam int PROD_W          = 64;
  localparam int MUL_LATENCY_DEF = 9;
  localparam int TAG_W_DEF       = 4;
  typedef struct packed {
    logic [PROD_W-1:0]    product;
    logic [TAG_W_DEF-1:0] tag;
  } res_entry_t;
endpackage

// File: rtl/mul_res_fifo.sv
// mul_res_fifo: first-word fall-through result FIFO.
// Ports: clk, rst_n (async active-low); wr/wdata push; rd pops head; rdata is the head; full, empty flags.
module mul_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  // extra pointer bit separates full from empty when the index bits match
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr && !full) begin
        mem[wp[AW-1:0]] <= wdata;
        wp <= wp + (AW+1)'(1);
      end
      if (rd && !empty) rp <= rp + (AW+1)'(1);
    end
  end
  // credits upstream guarantee a write never meets a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr && full));
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: credit-based valid/ready wrapper around a fixed-latency non-stallable multiplier.
// Ports: clk, rst_n (async active-low); s_valid/s_ready/s_a/s_b/s_tag operand input;
// mul_num1/mul_num2 to the multiplier, mul_product from it; m_valid/m_ready/m_product/m_tag
// result output in issue order; busy while anything is in flight or buffered.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [OP_W-1:0]   s_a,
  input  logic [OP_W-1:0]   s_b,
  input  logic [TAG_W-1:0]  s_tag,
  output logic [OP_W-1:0]   mul_num1,
  output logic [OP_W-1:0]   mul_num2,
  input  logic [PROD_W-1:0] mul_product,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PROD_W-1:0] m_product,
  output logic [TAG_W-1:0]  m_tag,
  output logic              busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = PROD_W + TAG_W;
  logic [CW-1:0]          outstanding;
  logic                   issue_q;
  logic [TAG_W-1:0]       issue_tag;
  logic [MUL_LATENCY-1:0] vld_sr;
  logic [TAG_W-1:0]       tag_sr [MUL_LATENCY];
  logic                   s_fire, m_fire, full, empty;
  logic [W-1:0]           rdata;
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;
  // outstanding covers both in-flight and buffered ops, so capping it at DEPTH keeps the FIFO from overflowing
  assign s_ready = outstanding < CW'(DEPTH);
  assign busy    = outstanding != '0;
  assign m_valid = !empty;
  assign {m_product, m_tag} = rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      issue_q     <= 1'b0;
      issue_tag   <= '0;
      mul_num1    <= '0;
      mul_num2    <= '0;
      vld_sr      <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) tag_sr[i] <= '0;
    end else begin
      issue_q <= s_fire;
      if (s_fire) begin
        mul_num1  <= s_a;
        mul_num2  <= s_b;
        issue_tag <= s_tag;
      end
      vld_sr    <= {vld_sr[MUL_LATENCY-2:0], issue_q};
      tag_sr[0] <= issue_tag;
      for (int i = 1; i < MUL_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
      outstanding <= outstanding + CW'(s_fire) - CW'(m_fire);
    end
  end
  mul_res_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (vld_sr[MUL_LATENCY-1]),
    .wdata ({mul_product, tag_sr[MUL_LATENCY-1]}),
    .rd    (m_fire),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );
endmodule
